// File: rtl/exe_stage_pipe.sv
// Registered execute stage: operand-2 shifter, ALU, iterative multiplier,
// NZCV status register and the EXE/MEM output register.
module exe_stage_pipe #(
    parameter int DATA_W   = 32,
    parameter int MUL_BITS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [3:0]        exe_cmd,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic              s_update,
    input  logic              imm,
    input  logic [11:0]       shift_operand,
    input  logic [DATA_W-1:0] val_rn,
    input  logic [DATA_W-1:0] val_rm,
    input  logic [3:0]        dest,
    input  logic              stall_in,
    output logic              busy,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_result,
    output logic [DATA_W-1:0] out_store_val,
    output logic [3:0]        out_dest,
    output logic              out_mem_r_en,
    output logic              out_mem_w_en,
    output logic [3:0]        status_out
);

    localparam int STEPS = DATA_W / MUL_BITS;
    localparam int CW    = $clog2(STEPS + 1);
    localparam int SW    = $clog2(DATA_W);

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MUL = 4'b1010;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              mul_s_q, mul_s_d;
    logic [3:0]        mul_dest_q, mul_dest_d;

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [DATA_W-1:0] store_q, store_d;
    logic [3:0]        dest_q, dest_d;
    logic              mem_r_q, mem_r_d;
    logic              mem_w_q, mem_w_d;
    logic [3:0]        status_q, status_d;

    function automatic logic [DATA_W-1:0] ror(
        input logic [DATA_W-1:0] x,
        input logic [SW-1:0]     r
    );
        logic [2*DATA_W-1:0] t;
        t = {x, x} >> r;
        return t[DATA_W-1:0];
    endfunction

    logic [DATA_W-1:0] val2;
    logic [4:0]        sh_amt;

    always_comb begin
        sh_amt = shift_operand[11:7];
        val2   = '0;
        if (imm) begin
            val2 = ror(DATA_W'(shift_operand[7:0]),
                       SW'({shift_operand[11:8], 1'b0}));
        end else if (mem_r_en || mem_w_en) begin
            val2 = DATA_W'(shift_operand);
        end else begin
            case (shift_operand[6:5])
                2'b00:   val2 = val_rm << sh_amt;
                2'b01:   val2 = val_rm >> sh_amt;
                2'b10:   val2 = DATA_W'($signed(val_rm) >>> sh_amt);
                default: val2 = ror(val_rm, SW'(sh_amt));
            endcase
        end
    end

    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W:0]   sum;
    logic              cin;
    logic              arith;
    logic              alu_ok;
    logic              ovf;
    logic [1:0]        cv;

    always_comb begin
        op_b    = val2;
        cin     = 1'b0;
        arith   = 1'b0;
        alu_ok  = 1'b1;
        alu_res = '0;
        case (exe_cmd)
            CMD_MOV: alu_res = val2;
            CMD_MVN: alu_res = ~val2;
            CMD_ADD: arith = 1'b1;
            CMD_ADC: begin arith = 1'b1; cin = status_q[1]; end
            CMD_SUB: begin arith = 1'b1; op_b = ~val2; cin = 1'b1; end
            CMD_SBC: begin arith = 1'b1; op_b = ~val2; cin = status_q[1]; end
            CMD_AND: alu_res = val_rn & val2;
            CMD_ORR: alu_res = val_rn | val2;
            CMD_EOR: alu_res = val_rn ^ val2;
            default: alu_ok = 1'b0;
        endcase
        sum = {1'b0, val_rn} + {1'b0, op_b} + {{DATA_W{1'b0}}, cin};
        if (arith) alu_res = sum[DATA_W-1:0];
        // Subtraction overflow falls out of the same test once b is inverted.
        ovf = (val_rn[DATA_W-1] == op_b[DATA_W-1]) &&
              (sum[DATA_W-1] != val_rn[DATA_W-1]);
        cv  = arith ? {sum[DATA_W], ovf} : status_q[1:0];
    end

    logic [DATA_W-1:0] partial;
    logic [DATA_W-1:0] acc_next;

    assign partial  = mcand_q * DATA_W'(mplier_q[MUL_BITS-1:0]);
    assign acc_next = acc_q + partial;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        mul_s_d    = mul_s_q;
        mul_dest_d = mul_dest_q;
        valid_d    = valid_q;
        result_d   = result_q;
        store_d    = store_q;
        dest_d     = dest_q;
        mem_r_d    = mem_r_q;
        mem_w_d    = mem_w_q;
        status_d   = status_q;
        if (!stall_in) begin
            valid_d = 1'b0;
            mem_r_d = 1'b0;
            mem_w_d = 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid && exe_cmd == CMD_MUL) begin
                        state_d    = S_MUL;
                        cnt_d      = CW'(STEPS);
                        mcand_d    = val_rn;
                        mplier_d   = val_rm;
                        acc_d      = '0;
                        mul_s_d    = s_update;
                        mul_dest_d = dest;
                    end else if (in_valid) begin
                        valid_d  = 1'b1;
                        result_d = alu_res;
                        store_d  = val_rm;
                        dest_d   = dest;
                        mem_r_d  = mem_r_en;
                        mem_w_d  = mem_w_en;
                        if (s_update && alu_ok && !mem_r_en && !mem_w_en)
                            status_d = {alu_res[DATA_W-1],
                                        (alu_res == '0), cv};
                    end
                end
                S_MUL: begin
                    acc_d    = acc_next;
                    mcand_d  = mcand_q << MUL_BITS;
                    mplier_d = mplier_q >> MUL_BITS;
                    cnt_d    = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d  = S_IDLE;
                        valid_d  = 1'b1;
                        result_d = acc_next;
                        store_d  = '0;
                        dest_d   = mul_dest_q;
                        if (mul_s_q)
                            status_d = {acc_next[DATA_W-1],
                                        (acc_next == '0), status_q[1:0]};
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            mul_s_q    <= 1'b0;
            mul_dest_q <= '0;
            valid_q    <= 1'b0;
            result_q   <= '0;
            store_q    <= '0;
            dest_q     <= '0;
            mem_r_q    <= 1'b0;
            mem_w_q    <= 1'b0;
            status_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            mul_s_q    <= mul_s_d;
            mul_dest_q <= mul_dest_d;
            valid_q    <= valid_d;
            result_q   <= result_d;
            store_q    <= store_d;
            dest_q     <= dest_d;
            mem_r_q    <= mem_r_d;
            mem_w_q    <= mem_w_d;
            status_q   <= status_d;
        end
    end

    assign busy          = (state_q == S_MUL);
    assign out_valid     = valid_q;
    assign out_result    = result_q;
    assign out_store_val = store_q;
    assign out_dest      = dest_q;
    assign out_mem_r_en  = mem_r_q;
    assign out_mem_w_en  = mem_w_q;
    assign status_out    = status_q;

endmodule

// File: tb/tb_exe_stage_pipe.sv
// Directed bench for exe_stage_pipe: ALU, shifter, status, multiplier,
// stall and reset behaviour with hand-computed expectations.
module tb_exe_stage_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [3:0]  exe_cmd;
    logic        mem_r_en;
    logic        mem_w_en;
    logic        s_update;
    logic        imm;
    logic [11:0] shift_operand;
    logic [31:0] val_rn;
    logic [31:0] val_rm;
    logic [3:0]  dest;
    logic        stall_in;
    logic        busy;
    logic        out_valid;
    logic [31:0] out_result;
    logic [31:0] out_store_val;
    logic [3:0]  out_dest;
    logic        out_mem_r_en;
    logic        out_mem_w_en;
    logic [3:0]  status_out;

    int n_chk  = 0;
    int n_fail = 0;

    exe_stage_pipe #(.DATA_W(32), .MUL_BITS(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .exe_cmd       (exe_cmd),
        .mem_r_en      (mem_r_en),
        .mem_w_en      (mem_w_en),
        .s_update      (s_update),
        .imm           (imm),
        .shift_operand (shift_operand),
        .val_rn        (val_rn),
        .val_rm        (val_rm),
        .dest          (dest),
        .stall_in      (stall_in),
        .busy          (busy),
        .out_valid     (out_valid),
        .out_result    (out_result),
        .out_store_val (out_store_val),
        .out_dest      (out_dest),
        .out_mem_r_en  (out_mem_r_en),
        .out_mem_w_en  (out_mem_w_en),
        .status_out    (status_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] c, input logic mr, input logic mw,
                         input logic s, input logic im,
                         input logic [11:0] so, input logic [31:0] rn,
                         input logic [31:0] rm, input logic [3:0] d);
        in_valid      = 1'b1;
        exe_cmd       = c;
        mem_r_en      = mr;
        mem_w_en      = mw;
        s_update      = s;
        imm           = im;
        shift_operand = so;
        val_rn        = rn;
        val_rm        = rm;
        dest          = d;
    endtask

    initial begin
        rst = 1'b0;
        stall_in = 1'b0;
        drive(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 32'h0, 4'h0);
        in_valid = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_result", out_result, 32'h0);
        chk("rst_store", out_store_val, 32'h0);
        chk("rst_dest", 32'(out_dest), 32'h0);
        chk("rst_mem", 32'({out_mem_r_en, out_mem_w_en}), 32'h0);
        chk("rst_status", 32'(status_out), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst = 1'b1;
        tick();
        chk("idle_valid", 32'(out_valid), 32'h0);

        // ADD overflow into sign bit
        drive(4'b0010, 1'b0, 1'b0, 1'b1, 1'b1, 12'h001,
              32'h7FFF_FFFF, 32'h0, 4'h3);
        tick();
        in_valid = 1'b0;
        chk("add_valid", 32'(out_valid), 32'h1);
        chk("add_result", out_result, 32'h8000_0000);
        chk("add_nzcv", 32'(status_out), 32'h9);
        chk("add_dest", 32'(out_dest), 32'h3);
        tick();
        chk("bubble_valid", 32'(out_valid), 32'h0);

        // SUB / SBC / ADC back-to-back
        drive(4'b0100, 1'b0, 1'b0, 1'b1, 1'b1, 12'h005,
              32'h5, 32'h0, 4'h1);
        tick();
        chk("sub_result", out_result, 32'h0);
        chk("sub_nzcv", 32'(status_out), 32'h6);
        drive(4'b0101, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000,
              32'h0, 32'h0, 4'h2);
        tick();
        chk("sbc_valid", 32'(out_valid), 32'h1);
        chk("sbc_result", out_result, 32'h0);
        chk("sbc_nzcv", 32'(status_out), 32'h6);
        drive(4'b0011, 1'b0, 1'b0, 1'b1, 1'b1, 12'h001,
              32'h1, 32'h0, 4'h4);
        tick();
        chk("adc_result", out_result, 32'h3);
        chk("adc_nzcv", 32'(status_out), 32'h0);

        // Operand 2 forms
        drive(4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, 12'h4FF,
              32'h0, 32'h0, 4'h5);
        tick();
        chk("imm_rot", out_result, 32'hFF00_0000);
        chk("imm_nzcv", 32'(status_out), 32'h0);
        drive(4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 12'h240,
              32'h0, 32'h8000_0000, 4'h5);
        tick();
        chk("asr4", out_result, 32'hF800_0000);
        chk("asr_nzcv", 32'(status_out), 32'h8);
        drive(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 12'h460,
              32'h0, 32'h1234_5678, 4'h5);
        tick();
        chk("ror8", out_result, 32'h7812_3456);
        drive(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 12'h220,
              32'h0, 32'hF000_0000, 4'h5);
        tick();
        chk("lsr4", out_result, 32'h0F00_0000);
        drive(4'b0010, 1'b0, 1'b1, 1'b1, 1'b0, 12'hABC,
              32'h1000, 32'hDEAD_BEEF, 4'h7);
        tick();
        chk("str_addr", out_result, 32'h0000_1ABC);
        chk("str_val", out_store_val, 32'hDEAD_BEEF);
        chk("str_wen", 32'({out_mem_r_en, out_mem_w_en}), 32'h1);
        chk("str_nzcv", 32'(status_out), 32'h8);

        // Set C and V so the multiply must preserve them
        drive(4'b0010, 1'b0, 1'b0, 1'b1, 1'b1, 12'h102,
              32'h8000_0000, 32'h0, 4'h1);
        tick();
        chk("addcv_result", out_result, 32'h0);
        chk("addcv_nzcv", 32'(status_out), 32'h7);

        // MUL with the next instruction held upstream
        drive(4'b1010, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000,
              32'h0001_0000, 32'h0001_0001, 4'h5);
        tick();
        drive(4'b0010, 1'b0, 1'b0, 1'b0, 1'b1, 12'h003,
              32'h2, 32'h0, 4'h6);
        chk("mul_e0_busy", 32'(busy), 32'h1);
        chk("mul_e0_valid", 32'(out_valid), 32'h0);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk($sformatf("mul_busy_%0d", i), 32'(busy), 32'h1);
            chk($sformatf("mul_valid_%0d", i), 32'(out_valid), 32'h0);
        end
        tick();
        chk("mul_busy_done", 32'(busy), 32'h0);
        chk("mul_valid", 32'(out_valid), 32'h1);
        chk("mul_result", out_result, 32'h0001_0000);
        chk("mul_dest", 32'(out_dest), 32'h5);
        chk("mul_nzcv", 32'(status_out), 32'h3);
        tick();
        in_valid = 1'b0;
        chk("post_mul_add", out_result, 32'h5);
        chk("post_mul_dest", 32'(out_dest), 32'h6);
        chk("post_mul_nzcv", 32'(status_out), 32'h3);

        // MUL with stall covering the completion edge
        drive(4'b1010, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000,
              32'h3, 32'h7, 4'h9);
        tick();
        in_valid = 1'b0;
        for (int i = 1; i < 8; i++) tick();
        stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("mstall_busy_%0d", i), 32'(busy), 32'h1);
            chk($sformatf("mstall_valid_%0d", i), 32'(out_valid), 32'h0);
        end
        stall_in = 1'b0;
        tick();
        chk("mstall_valid", 32'(out_valid), 32'h1);
        chk("mstall_result", out_result, 32'h15);
        chk("mstall_busy", 32'(busy), 32'h0);
        tick();
        chk("mstall_bubble", 32'(out_valid), 32'h0);

        // Stall while an ADD sits in the output register
        drive(4'b0010, 1'b0, 1'b0, 1'b0, 1'b1, 12'h020,
              32'h10, 32'h0, 4'h1);
        tick();
        chk("sadd_result", out_result, 32'h30);
        drive(4'b0111, 1'b0, 1'b0, 1'b0, 1'b1, 12'h00F,
              32'hF0, 32'h0, 4'h2);
        stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("astall_valid_%0d", i), 32'(out_valid), 32'h1);
            chk($sformatf("astall_result_%0d", i), out_result, 32'h30);
            chk($sformatf("astall_dest_%0d", i), 32'(out_dest), 32'h1);
        end
        stall_in = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("orr_result", out_result, 32'hFF);
        chk("orr_dest", 32'(out_dest), 32'h2);
        tick();
        chk("orr_no_dup", 32'(out_valid), 32'h0);

        // Reset during a multiply
        drive(4'b1010, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000,
              32'h5, 32'h5, 4'h3);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("pre_rst_busy", 32'(busy), 32'h1);
        rst = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_valid", 32'(out_valid), 32'h0);
        chk("arst_status", 32'(status_out), 32'h0);
        chk("arst_result", out_result, 32'h0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("arst_no_result", 32'(out_valid), 32'h0);
        chk("arst_no_flags", 32'(status_out), 32'h0);
        chk("arst_idle", 32'(busy), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
